instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 118 +++++++++++
 tb/tb_instr_fetch.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch unit: a small program memory that is loaded while idle and then
// issues prog_len words from address 0, one per unstalled cycle, with a done pulse.
module instr_fetch #(
  parameter int INSTR_WIDTH = 20,
  parameter int ADDR_BITS   = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stall,
  input  logic [ADDR_BITS:0]     prog_len,
  input  logic                   prog_we,
  input  logic [ADDR_BITS-1:0]   prog_addr,
  input  logic [INSTR_WIDTH-1:0] prog_data,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   instr_valid,
  output logic [ADDR_BITS-1:0]   pc,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_BITS-1:0]   pc_q, pc_d;
  logic [ADDR_BITS:0]     cnt_q, cnt_d;
  logic [ADDR_BITS:0]     len_q, len_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic [INSTR_WIDTH-1:0] mem [0:(1<<ADDR_BITS)-1];

  // Memory is deliberately outside the reset domain so a program survives reset.
  always_ff @(posedge clk) begin
    if (prog_we && (state_q == IDLE)) begin
      mem[prog_addr] <= prog_data;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    instr_d = '0;
    valid_d = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          pc_d  = '0;
          cnt_d = '0;
          len_d = prog_len;
          if (prog_len == '0) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (!stall) begin
          instr_d = mem[pc_q];
          valid_d = 1'b1;
          pc_d    = pc_q + 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_d == len_q) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        // Outputs are registered, so the done pulse appears as DONE is left.
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed programs against a queue-based model of issued words.
module tb_instr_fetch;

  logic        clk, rst, start, stall, prog_we;
  logic [5:0]  prog_len;
  logic [4:0]  prog_addr;
  logic [19:0] prog_data;
  logic [19:0] instruction;
  logic        instr_valid, busy, done;
  logic [4:0]  pc;

  instr_fetch #(.INSTR_WIDTH(20), .ADDR_BITS(5)) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall), .prog_len(prog_len),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .instruction(instruction), .instr_valid(instr_valid), .pc(pc),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int valid_cnt = 0;
  logic        done_pending = 1'b0;
  logic [19:0] model_mem [32];
  logic [19:0] exp_q[$];
  logic [4:0]  exp_pc_q[$];
  logic [19:0] got_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle check against the model: issued words in order, zero when idle,
  // busy while words are owed, and exactly one done after the last word.
  always @(negedge clk) begin
    if (!rst) begin
      if (instr_valid) begin
        valid_cnt++;
        got_q.push_back(instruction);
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", {31'd0, instr_valid}, 32'd0);
        end else begin
          chk("instr", {12'd0, instruction}, {12'd0, exp_q[0]});
          chk("pc_after_issue", {27'd0, pc}, {27'd0, exp_pc_q[0]});
          void'(exp_q.pop_front());
          void'(exp_pc_q.pop_front());
        end
      end else begin
        chk("instr_zero_when_invalid", {12'd0, instruction}, 32'd0);
      end
      chk("busy", {31'd0, busy}, {31'd0, exp_q.size() != 0});
      if (done) begin
        done_cnt++;
        chk("done_expected", {31'd0, done_pending}, 32'd1);
        chk("done_after_last", exp_q.size(), 32'd0);
        chk("done_valid_low", {31'd0, instr_valid}, 32'd0);
        done_pending = 1'b0;
      end
    end
  end

  task automatic write_word(input logic [4:0] a, input logic [19:0] d, input bit in_idle);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    @(posedge clk); #1;
    prog_we = 1'b0;
    if (in_idle) model_mem[a] = d;
  endtask

  task automatic expect_run(input int len);
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(model_mem[i % 32]);
      exp_pc_q.push_back(5'((i + 1) % 32));
    end
    done_pending = 1'b1;
  endtask

  task automatic start_run(input int len);
    start = 1'b1; prog_len = 6'(len);
    @(posedge clk); #1;
    start = 1'b0;
    expect_run(len);
  endtask

  task automatic wait_done(input int budget);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) @(posedge clk);
    chk("done_timeout", {31'd0, done_cnt != d0}, 32'd1);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0;
    int v0;
    rst = 1'b1; start = 1'b0; stall = 1'b0; prog_we = 1'b0;
    prog_len = '0; prog_addr = '0; prog_data = '0;
    for (int i = 0; i < 32; i++) model_mem[i] = 'x;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_instr", {12'd0, instruction}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_pc", {27'd0, pc}, 32'd0);
    chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic three-word program
    write_word(5'd0, 20'h12345, 1);
    write_word(5'd1, 20'h0ABCD, 1);
    write_word(5'd2, 20'hFFFFF, 1);
    got_q.delete();
    start_run(3);
    @(negedge clk);
    chk("b_first_cycle_busy", {31'd0, busy}, 32'd1);
    chk("b_first_cycle_invalid", {31'd0, instr_valid}, 32'd0);
    @(negedge clk);
    chk("b_w0", {11'd0, instr_valid, instruction}, 32'h112345);
    @(negedge clk);
    chk("b_w1", {11'd0, instr_valid, instruction}, 32'h10ABCD);
    @(negedge clk);
    chk("b_w2", {11'd0, instr_valid, instruction}, 32'h1FFFFF);
    @(negedge clk);
    chk("b_done", {29'd0, done, instr_valid, busy}, 32'd4);
    @(negedge clk);
    chk("b_idle", {30'd0, done, busy}, 32'd0);
    @(posedge clk); #1;

    // Single stall bubble after the first issue
    got_q.delete();
    start_run(3);
    @(posedge clk); #1;
    stall = 1'b1;
    @(posedge clk); #1;
    stall = 1'b0;
    @(negedge clk);
    chk("s_bubble_valid", {31'd0, instr_valid}, 32'd0);
    chk("s_bubble_pc", {27'd0, pc}, 32'd1);
    wait_done(10);
    chk("s_count", got_q.size(), 32'd3);
    if (got_q.size() == 3) chk("s_w1", {12'd0, got_q[1]}, 32'h0ABCD);

    // Writes and start during RUN are ignored
    start_run(3);
    @(posedge clk); #1;
    prog_we = 1'b1; prog_addr = 5'd1; prog_data = 20'h55555;
    start = 1'b1; prog_len = 6'd5;
    @(posedge clk); #1;
    prog_we = 1'b0; start = 1'b0;
    wait_done(10);
    repeat (3) @(posedge clk);
    #1;
    got_q.delete();
    start_run(3);
    wait_done(10);
    if (got_q.size() == 3) chk("r_w1_unchanged", {12'd0, got_q[1]}, 32'h0ABCD);
    else chk("r_count", got_q.size(), 32'd3);

    // Reset mid-run aborts with no done, program replays afterwards
    start_run(3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    d0 = done_cnt;
    rst = 1'b1;
    exp_q.delete(); exp_pc_q.delete(); done_pending = 1'b0;
    #1;
    chk("a_instr", {12'd0, instruction}, 32'd0);
    chk("a_flags", {29'd0, instr_valid, busy, done}, 32'd0);
    chk("a_pc", {27'd0, pc}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("a_no_done", done_cnt, d0);
    got_q.delete();
    start_run(3);
    wait_done(10);
    if (got_q.size() == 3) chk("a_replay_w0", {12'd0, got_q[0]}, 32'h12345);
    else chk("a_replay_count", got_q.size(), 32'd3);

    // Zero-length program
    start_run(0);
    @(negedge clk);
    chk("z_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("z_done", {30'd0, done, instr_valid}, 32'd2);
    @(posedge clk); #1;

    // Full 32-word program with pc wrap
    for (int i = 0; i < 32; i++) write_word(5'(i), 20'(i), 1);
    v0 = valid_cnt;
    d0 = done_cnt;
    start_run(32);
    wait_done(50);
    chk("f_valid_count", valid_cnt - v0, 32'd32);
    chk("f_single_done", done_cnt - d0, 32'd1);
    chk("f_pc_wrapped", {27'd0, pc}, 32'd0);

    // Write and start in the same idle cycle
    prog_we = 1'b1; prog_addr = 5'd0; prog_data = 20'hA5A5A;
    start = 1'b1; prog_len = 6'd1;
    @(posedge clk); #1;
    prog_we = 1'b0; start = 1'b0;
    model_mem[0] = 20'hA5A5A;
    expect_run(1);
    got_q.delete();
    wait_done(10);
    if (got_q.size() == 1) chk("ws_word", {12'd0, got_q[0]}, 32'hA5A5A);
    else chk("ws_count", got_q.size(), 32'd1);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
